ex_alu_unit: RTL and testbench
==============================

// Module: ex_alu_unit
// PURPOSE
//  EX-stage execute unit; consumes the 6-bit ALUControl code from ALU control plus ID/EX operands.
//  Single-cycle ops: logic, add/sub, shift, slt. MUL: iterative 32-step shift-add engine
//  that stalls the pipeline. Results and flags are registered for the EX/MEM register.
// PARAMETERS
//  DATA_W   32  operand/result width
//  MUL_CYC  32  MUL iterations; must equal DATA_W
// PORTS
//  Clk         in   1   single clock; all state updates on posedge
//  Rst_n       in   1   synchronous, active-low reset
//  InValid     in   1   op presented this cycle
//  InReady     out  1   unit can accept; high only in IDLE
//  ALUControl  in   6   op code from ALU control
//  A           in   32  rs operand
//  B           in   32  rt operand / immediate
//  Shamt       in   5   shift amount for SLL/SRL
//  OutValid    out  1   one-cycle pulse: Result/flags valid
//  Result      out  32  registered result
//  Zero        out  1   Result == 0
//  Negative    out  1   Result[31]
//  Illegal     out  1   unrecognised code; qualified by OutValid
//  Busy        out  1   MUL in progress; drives pipeline stall
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): state=IDLE; Result=0; Zero=1; Negative=0; Illegal=0; OutValid=0; Busy=0.
//  Accept = InValid & InReady. While InReady=0, InValid is ignored; no queuing.
//  States: IDLE -> (accept MUL 011000) -> MUL_RUN -> IDLE; any other accepted op stays in IDLE.
//  Single-cycle latency: OutValid high the cycle after the accept cycle.
//  Op map: 100000 ADD, 101000/101001/100001 address ADD, 100010 SUB, 000001 branch compare (A-B),
//   100100 AND, 100101 OR, 100111 NOR, 100110 XOR, 000000 SLL (B<<Shamt), 000010 SRL (B>>Shamt logical),
//   101010 SLT (signed A<B ? 1 : 0), 011000 MUL (low 32 bits of A*B).
//  Arithmetic is modulo 2^32; no overflow trap. MUL low word is sign-agnostic, so unsigned shift-add.
//  Any other code: Result=0, Zero=1, Illegal=1, OutValid pulses after 1 cycle.
//  MUL_RUN: load mcand=A, mplier=B, acc=0, cnt=MUL_CYC on accept. Each cycle: acc+=mplier[0]?mcand:0;
//   mcand<<=1; mplier>>=1; cnt-=1. When cnt reaches 0, Result=acc, OutValid=1, return to IDLE.
//   MUL latency: 33 cycles accept->OutValid. Busy=1 and InReady=0 for the whole MUL_RUN.
//  OutValid is never back-to-back with MUL; an op may be accepted in the cycle OutValid is high.
//  Reset mid-MUL: aborts, no OutValid, all outputs to reset values next cycle.
//  Result/flags hold their last value until the next OutValid.
// CONFIGURATION
//  ALU_MUL_EARLY_TERM_EN defined: MUL_RUN also completes at the step where the shifted mplier
//   becomes 0; latency = 1 + max(1, index of B's highest set bit + 1) (B=0 or 1 -> 2, B=3 -> 3).
//  Undefined: fixed 33-cycle MUL latency regardless of operands; results are identical either way.
// STRUCTURE
//  Shared package alu_pkg: ALUControl op-code localparams (shared with ALU control),
//   EX state encoding (IDLE, MUL_RUN), DATA_W.
//  One sub-module: ex_iter_mul (start/done handshake, acc/mcand/mplier/cnt regs, early-term logic).
//  Top level holds the op decode, single-cycle datapath, output register, and FSM.
// TESTING
//  ADD A=5 B=7 -> next cycle OutValid=1, Result=12, Zero=0, Illegal=0.
//  Branch compare 000001 A=B=0x1234 -> Result=0, Zero=1; SLT A=0xFFFFFFFF B=1 -> Result=1.
//  SLL B=1 Shamt=31 -> 0x80000000, Negative=1; SRL B=0x80000000 Shamt=31 -> 0x00000001.
//  MUL A=0xFFFFFFFF B=3 -> Busy/!InReady for 32 cycles, OutValid at 33, Result=0xFFFFFFFD;
//   InValid held high with ADD during MUL is not accepted.
//  Rst_n low on cycle 10 of MUL -> no OutValid, Result=0, Busy=0, next ADD accepted normally.
//  Code 6'b111111 -> Illegal=1, Result=0; with ALU_MUL_EARLY_TERM_EN, MUL A=9 B=1 -> OutValid at 2, Result=9.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl op codes shared with ALU control, EX-stage state encoding
// and the default datapath width.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [5:0] ALU_SLL    = 6'b000000;
   localparam logic [5:0] ALU_BCMP   = 6'b000001;
   localparam logic [5:0] ALU_SRL    = 6'b000010;
   localparam logic [5:0] ALU_MUL    = 6'b011000;
   localparam logic [5:0] ALU_ADD    = 6'b100000;
   localparam logic [5:0] ALU_ADDR_C = 6'b100001;
   localparam logic [5:0] ALU_SUB    = 6'b100010;
   localparam logic [5:0] ALU_AND    = 6'b100100;
   localparam logic [5:0] ALU_OR     = 6'b100101;
   localparam logic [5:0] ALU_XOR    = 6'b100110;
   localparam logic [5:0] ALU_NOR    = 6'b100111;
   localparam logic [5:0] ALU_ADDR_A = 6'b101000;
   localparam logic [5:0] ALU_ADDR_B = 6'b101001;
   localparam logic [5:0] ALU_SLT    = 6'b101010;

   typedef enum logic {
      EX_IDLE    = 1'b0,
      EX_MUL_RUN = 1'b1
   } ex_state_t;

endpackage

// File: rtl/ex_iter_mul.sv
// ex_iter_mul: iterative shift-add multiplier producing the low DATA_W bits of op_a*op_b.
// Optional early completion when the multiplier runs out of set bits: ALU_MUL_EARLY_TERM_EN.
module ex_iter_mul #(
   parameter int DATA_W  = 32,
   parameter int MUL_CYC = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              done,
   output logic [DATA_W-1:0] product
);
   import alu_pkg::*;

   localparam int CNT_W = $clog2(MUL_CYC + 1);

   logic              running;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc_step;
   logic [CNT_W-1:0]  cnt;
   logic              last_step;

   assign acc_step = acc + (mplier[0] ? mcand : '0);

   // done is combinational on the final step so the top can register acc_step
   // in the same edge that retires the last iteration.
`ifdef ALU_MUL_EARLY_TERM_EN
   assign last_step = (cnt == CNT_W'(1)) || (mplier[DATA_W-1:1] == '0);
`else
   assign last_step = (cnt == CNT_W'(1));
`endif

   assign done    = running & last_step;
   assign product = acc_step;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         running <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         acc     <= '0;
         mcand   <= op_a;
         mplier  <= op_b;
         cnt     <= CNT_W'(MUL_CYC);
      end else if (running) begin
         acc     <= acc_step;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         cnt     <= cnt - CNT_W'(1);
         if (last_step) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage execute unit with single-cycle ops and an iterative MUL that stalls.
// Optional MUL early termination is selected with ALU_MUL_EARLY_TERM_EN.
module ex_alu_unit #(
   parameter int DATA_W  = alu_pkg::DATA_W,
   parameter int MUL_CYC = alu_pkg::DATA_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              InValid,
   output logic              InReady,
   input  logic [5:0]        ALUControl,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [4:0]        Shamt,
   output logic              OutValid,
   output logic [DATA_W-1:0] Result,
   output logic              Zero,
   output logic              Negative,
   output logic              Illegal,
   output logic              Busy,
   output logic              dbg_state
);
   import alu_pkg::*;

   ex_state_t         state_q;
   ex_state_t         state_d;
   logic              accept;
   logic              is_mul;
   logic              dec_illegal;
   logic              mul_start;
   logic              mul_done;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] mul_res;

   logic              out_valid_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              negative_q;
   logic              illegal_q;

   // Handshake: an op transfers when InValid && InReady at a posedge. InReady is
   // high only in IDLE; InValid is ignored otherwise and nothing is queued.
   assign InReady   = (state_q == EX_IDLE);
   assign Busy      = (state_q == EX_MUL_RUN);
   assign dbg_state = (state_q == EX_MUL_RUN);
   assign accept    = InValid & InReady;
   assign mul_start = accept & is_mul;

   always_comb begin
      alu_res     = '0;
      dec_illegal = 1'b0;
      is_mul      = 1'b0;
      case (ALUControl)
         ALU_ADD, ALU_ADDR_A, ALU_ADDR_B, ALU_ADDR_C: alu_res = A + B;
         ALU_SUB, ALU_BCMP:                           alu_res = A - B;
         ALU_AND:                                     alu_res = A & B;
         ALU_OR:                                      alu_res = A | B;
         ALU_NOR:                                     alu_res = ~(A | B);
         ALU_XOR:                                     alu_res = A ^ B;
         ALU_SLL:                                     alu_res = B << Shamt;
         ALU_SRL:                                     alu_res = B >> Shamt;
         ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
         ALU_MUL:                                     is_mul  = 1'b1;
         default:                                     dec_illegal = 1'b1;
      endcase
   end

   ex_iter_mul #(
      .DATA_W  (DATA_W),
      .MUL_CYC (MUL_CYC)
   ) u_mul (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .start   (mul_start),
      .op_a    (A),
      .op_b    (B),
      .done    (mul_done),
      .product (mul_res)
   );

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= EX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EX_IDLE:    if (mul_start) state_d = EX_MUL_RUN;
         EX_MUL_RUN: if (mul_done)  state_d = EX_IDLE;
      endcase
   end

   // Illegal codes decode to a zero result, so Zero follows naturally.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         negative_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept && !is_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
            negative_q  <= alu_res[DATA_W-1];
            illegal_q   <= dec_illegal;
         end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
            zero_q      <= (mul_res == '0);
            negative_q  <= mul_res[DATA_W-1];
            illegal_q   <= 1'b0;
         end
      end
   end

   assign OutValid = out_valid_q;
   assign Result   = result_q;
   assign Zero     = zero_q;
   assign Negative = negative_q;
   assign Illegal  = illegal_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed vector table, hand-written MUL/reset sequences and
// randomized ops checked against an arithmetic reference model.
module tb_ex_alu_unit;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        InValid;
   logic        InReady;
   logic [5:0]  ALUControl;
   logic [31:0] A;
   logic [31:0] B;
   logic [4:0]  Shamt;
   logic        OutValid;
   logic [31:0] Result;
   logic        Zero;
   logic        Negative;
   logic        Illegal;
   logic        Busy;
   logic        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   ex_alu_unit dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .InValid    (InValid),
      .InReady    (InReady),
      .ALUControl (ALUControl),
      .A          (A),
      .B          (B),
      .Shamt      (Shamt),
      .OutValid   (OutValid),
      .Result     (Result),
      .Zero       (Zero),
      .Negative   (Negative),
      .Illegal    (Illegal),
      .Busy       (Busy),
      .dbg_state  (dbg_state)
   );

   always #5 Clk = ~Clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        ill;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference model: plain arithmetic from the op map.
   function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, output logic [31:0] r, output logic ill);
      r   = 32'd0;
      ill = 1'b0;
      case (op)
         6'b100000, 6'b101000, 6'b101001, 6'b100001: r = a + b;
         6'b100010, 6'b000001: r = a - b;
         6'b100100: r = a & b;
         6'b100101: r = a | b;
         6'b100111: r = ~(a | b);
         6'b100110: r = a ^ b;
         6'b000000: r = b << sh;
         6'b000010: r = b >> sh;
         6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'b011000: r = a * b;
         default:   ill = 1'b1;
      endcase
   endfunction

   function automatic int mul_latency(input logic [31:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
      int h = 0;
      for (int i = 0; i < 32; i++) if (b[i]) h = i;
      return 1 + ((h + 1 > 1) ? h + 1 : 1);
`else
      return 33;
`endif
   endfunction

   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] exp_res, input logic exp_ill,
                         input string tag);
      int   lat;
      int   exp_lat;
      logic stall_ok;
      exp_lat = (op == 6'b011000) ? mul_latency(b) : 1;
      check({tag, " in_ready"}, InReady, 1);
      InValid    = 1'b1;
      ALUControl = op;
      A          = a;
      B          = b;
      Shamt      = sh;
      tick();
      InValid    = 1'b0;
      ALUControl = 6'($urandom);
      A          = $urandom;
      B          = $urandom;
      lat        = 1;
      stall_ok   = 1'b1;
      while (!OutValid && lat < 40) begin
         if (!(Busy && !InReady)) stall_ok = 1'b0;
         tick();
         lat++;
      end
      check({tag, " out_valid"}, OutValid, 1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, Result, exp_res);
      check({tag, " zero"}, Zero, (exp_res == 32'd0));
      check({tag, " negative"}, Negative, exp_res[31]);
      check({tag, " illegal"}, Illegal, exp_ill);
      if (op == 6'b011000) begin
         check({tag, " mul_stall"}, stall_ok, 1);
         check({tag, " busy_after"}, Busy, 0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " out_valid"}, OutValid, 0);
      check({tag, " result"}, Result, 0);
      check({tag, " zero"}, Zero, 1);
      check({tag, " negative"}, Negative, 0);
      check({tag, " illegal"}, Illegal, 0);
      check({tag, " busy"}, Busy, 0);
      check({tag, " in_ready"}, InReady, 1);
      check({tag, " dbg_state"}, dbg_state, 0);
   endtask

   initial begin
      logic [5:0]  codes[12];
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] er;
      logic [31:0] held;
      logic [4:0]  sh;
      logic        ei;
      int          lat;
      int          pulses;

      vecs[0]  = '{6'b100000, 32'd5,         32'd7,         5'd0,  32'd12,        1'b0};
      vecs[1]  = '{6'b000001, 32'h1234,      32'h1234,      5'd0,  32'd0,         1'b0};
      vecs[2]  = '{6'b101010, 32'hFFFFFFFF,  32'd1,         5'd0,  32'd1,         1'b0};
      vecs[3]  = '{6'b000000, 32'd0,         32'd1,         5'd31, 32'h80000000,  1'b0};
      vecs[4]  = '{6'b000010, 32'd0,         32'h80000000,  5'd31, 32'h00000001,  1'b0};
      vecs[5]  = '{6'b111111, 32'hDEAD,      32'hBEEF,      5'd3,  32'd0,         1'b1};
      vecs[6]  = '{6'b100010, 32'd3,         32'd5,         5'd0,  32'hFFFFFFFE,  1'b0};
      vecs[7]  = '{6'b100100, 32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'hF000F000,  1'b0};
      vecs[8]  = '{6'b100101, 32'hF0F0F0F0,  32'h0F0F0F0F,  5'd0,  32'hFFFFFFFF,  1'b0};
      vecs[9]  = '{6'b100111, 32'd0,         32'd0,         5'd0,  32'hFFFFFFFF,  1'b0};
      vecs[10] = '{6'b100110, 32'hAAAAAAAA,  32'hFFFFFFFF,  5'd0,  32'h55555555,  1'b0};
      vecs[11] = '{6'b101001, 32'hFFFFFFFF,  32'd1,         5'd0,  32'd0,         1'b0};
      vecs[12] = '{6'b101010, 32'd1,         32'hFFFFFFFF,  5'd0,  32'd0,         1'b0};
      vecs[13] = '{6'b011000, 32'hFFFFFFFF,  32'd3,         5'd0,  32'hFFFFFFFD,  1'b0};
      vecs[14] = '{6'b011000, 32'd9,         32'd1,         5'd0,  32'd9,         1'b0};
      vecs[15] = '{6'b100001, 32'h7FFFFFFF,  32'd1,         5'd0,  32'h80000000,  1'b0};
      vecs[16] = '{6'b101000, 32'd10,        32'd20,        5'd0,  32'd30,        1'b0};
      vecs[17] = '{6'b000010, 32'd0,         32'hFFFFFFFF,  5'd4,  32'h0FFFFFFF,  1'b0};
      vecs[18] = '{6'b011000, 32'h12345678,  32'd0,         5'd0,  32'd0,         1'b0};
      vecs[19] = '{6'b101010, 32'h80000000,  32'h7FFFFFFF,  5'd0,  32'd1,         1'b0};
      vecs[20] = '{6'b000000, 32'd0,         32'd3,         5'd0,  32'd3,         1'b0};

      codes = '{6'b100000, 6'b101000, 6'b101001, 6'b100001, 6'b100010, 6'b000001,
                6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b000000, 6'b000010};

      // clock/reset
      Rst_n      = 1'b0;
      InValid    = 1'b0;
      ALUControl = 6'd0;
      A          = 32'd0;
      B          = 32'd0;
      Shamt      = 5'd0;
      repeat (3) tick();
      check_reset_values("reset");
      Rst_n = 1'b1;

      // directed vector table
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].res, vecs[i].ill,
                $sformatf("vec%0d", i));
      end

      // result holds through an idle cycle
      held = Result;
      tick();
      check("hold out_valid", OutValid, 0);
      check("hold result", Result, held);

      // ADD held on InValid during a MUL is not taken until the MUL completes
      InValid    = 1'b1;
      ALUControl = 6'b011000;
      A          = 32'hFFFFFFFF;
      B          = 32'd3;
      tick();
      ALUControl = 6'b100000;
      A          = 32'd5;
      B          = 32'd7;
      lat        = 1;
      while (!OutValid && lat < 40) begin
         tick();
         lat++;
      end
      check("mulhold latency", 32'(lat), 32'(mul_latency(32'd3)));
      check("mulhold result", Result, 32'hFFFFFFFD);
      tick();
      InValid = 1'b0;
      check("mulhold add out_valid", OutValid, 1);
      check("mulhold add result", Result, 32'd12);
      tick();
      check("mulhold no extra", OutValid, 0);

      // reset in cycle 10 of a MUL aborts it
      InValid    = 1'b1;
      ALUControl = 6'b011000;
      A          = 32'hFFFFFFFF;
      B          = 32'hFFFFFFFF;
      tick();
      InValid = 1'b0;
      repeat (9) tick();
      check("midmul busy", Busy, 1);
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      check_reset_values("midmul_rst");
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (OutValid) pulses++;
      end
      check("midmul no out_valid", 32'(pulses), 0);
      run_op(6'b100000, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, "post_rst_add");

      // randomized ops vs reference model
      for (int i = 0; i < 150; i++) begin
         if (i % 10 == 0) op = 6'b011000;
         else if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         else op = codes[$urandom_range(0, 11)];
         a  = $urandom;
         b  = $urandom;
         sh = 5'($urandom);
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
         ref_alu(op, a, b, sh, er, ei);
         run_op(op, a, b, sh, er, ei, $sformatf("rand%0d op=%b", i, op));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
